dft_uart_tx: RTL and testbench

DFT_UART_TX -- requirements
Module: dft_uart_tx

---
 rtl/dft_uart_tx.sv | 205 ++++++++++++++++++++
 tb/tb_dft_uart_tx.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dft_uart_tx.sv
// dft_uart_tx
// Streams processor register-file writes out of a UART for debug visibility.
// Every write to a non-zero register is captured into a small FIFO and sent
// as a 6-byte frame: 0xA5, {3'b000, addr[4:0]}, data[31:24] .. data[7:0].
// Each byte is 8N1, LSB first, CLKS_PER_BIT clocks per bit. Frames and bytes
// are sent back to back with no idle bit time between them.
//
// Ports
//   clk            : single clock, rising edge
//   rst            : synchronous, active-high reset
//   DFT_RegWrite   : register-file write strobe, one capture per high cycle
//   DFT_Address_in : destination register index, bits [4:0] used
//   DFT_data       : value written to the register file
//   tx             : UART serial output, idle high, registered
//   busy           : frame in flight or FIFO non-empty
//   overflow       : sticky, a capture was dropped because the FIFO was full
//
// FIFO_DEPTH must be a power of two, at least 2. CLKS_PER_BIT must be >= 2.
module dft_uart_tx #(
    parameter int BIT_WIDTH    = 32,
    parameter int CLKS_PER_BIT = 434,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 DFT_RegWrite,
    input  logic [BIT_WIDTH-1:0] DFT_Address_in,
    input  logic [BIT_WIDTH-1:0] DFT_data,
    output logic                 tx,
    output logic                 busy,
    output logic                 overflow
);

    localparam int PTR_W   = $clog2(FIFO_DEPTH);
    localparam int CNT_W   = PTR_W + 1;
    localparam int CLK_W   = $clog2(CLKS_PER_BIT);
    localparam int ENTRY_W = 5 + BIT_WIDTH;

    typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

    // FIFO storage and control
    logic [ENTRY_W-1:0]   r_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]     r_wr_ptr;
    logic [PTR_W-1:0]     r_rd_ptr;
    logic [CNT_W-1:0]     r_count;
    logic                 r_overflow;

    // Transmit FSM
    state_t               r_state;
    logic [CLK_W-1:0]     r_clk_cnt;
    logic [2:0]           r_bit_idx;
    logic [2:0]           r_byte_idx;
    logic [4:0]           r_frame_addr;
    logic [BIT_WIDTH-1:0] r_frame_data;
    logic                 r_tx;

    logic                 w_push_req;
    logic                 w_push;
    logic                 w_pop;
    logic                 w_full_block;
    logic                 w_fifo_nempty;
    logic                 w_bit_end;
    logic                 w_frame_end;
    logic [ENTRY_W-1:0]   w_head;
    logic [31:0]          w_data32;
    logic [7:0]           w_cur_byte;
    logic                 w_unused_addr;

    // Only the 5-bit register index is meaningful; the rest is discarded.
    assign w_unused_addr = ^DFT_Address_in[BIT_WIDTH-1:5];

    function automatic logic [7:0] frame_byte(input logic [2:0]  idx,
                                              input logic [4:0]  addr,
                                              input logic [31:0] data);
        case (idx)
            3'd0:    frame_byte = 8'hA5;
            3'd1:    frame_byte = {3'b000, addr};
            3'd2:    frame_byte = data[31:24];
            3'd3:    frame_byte = data[23:16];
            3'd4:    frame_byte = data[15:8];
            default: frame_byte = data[7:0];
        endcase
    endfunction

    // Frame payload is always presented as 32 bits on the wire.
    generate
        if (BIT_WIDTH >= 32) begin : g_data_trunc
            assign w_data32 = r_frame_data[31:0];
        end else begin : g_data_ext
            assign w_data32 = {{(32-BIT_WIDTH){1'b0}}, r_frame_data};
        end
    endgenerate

    assign w_fifo_nempty = (r_count != '0);
    assign w_head        = r_mem[r_rd_ptr];
    assign w_bit_end     = (r_clk_cnt == CLK_W'(CLKS_PER_BIT - 1));
    assign w_frame_end   = (r_state == S_STOP) && w_bit_end && (r_byte_idx == 3'd5);
    assign w_pop         = w_fifo_nempty && ((r_state == S_IDLE) || w_frame_end);
    // A full FIFO still accepts a write when the head leaves in the same cycle.
    assign w_full_block  = (r_count == CNT_W'(FIFO_DEPTH)) && !w_pop;
    assign w_push_req    = DFT_RegWrite && (DFT_Address_in[4:0] != 5'd0);
    assign w_push        = w_push_req && !w_full_block;
    assign w_cur_byte    = frame_byte(r_byte_idx, r_frame_addr, w_data32);

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= {DFT_Address_in[4:0], DFT_data};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
            if (w_push_req && !w_push) r_overflow <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_clk_cnt    <= '0;
            r_bit_idx    <= '0;
            r_byte_idx   <= '0;
            r_frame_addr <= '0;
            r_frame_data <= '0;
            r_tx         <= 1'b1;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_tx      <= 1'b1;
                    r_clk_cnt <= '0;
                    if (w_fifo_nempty) begin
                        r_state      <= S_START;
                        r_tx         <= 1'b0;
                        r_byte_idx   <= '0;
                        r_frame_addr <= w_head[ENTRY_W-1 -: 5];
                        r_frame_data <= w_head[BIT_WIDTH-1:0];
                    end
                end
                S_START: begin
                    if (w_bit_end) begin
                        r_clk_cnt <= '0;
                        r_bit_idx <= '0;
                        r_state   <= S_DATA;
                        r_tx      <= w_cur_byte[0];
                    end else begin
                        r_clk_cnt <= r_clk_cnt + 1'b1;
                    end
                end
                S_DATA: begin
                    if (w_bit_end) begin
                        r_clk_cnt <= '0;
                        if (r_bit_idx == 3'd7) begin
                            r_state <= S_STOP;
                            r_tx    <= 1'b1;
                        end else begin
                            r_bit_idx <= r_bit_idx + 1'b1;
                            r_tx      <= w_cur_byte[r_bit_idx + 3'd1];
                        end
                    end else begin
                        r_clk_cnt <= r_clk_cnt + 1'b1;
                    end
                end
                S_STOP: begin
                    if (w_bit_end) begin
                        r_clk_cnt <= '0;
                        if (r_byte_idx != 3'd5) begin
                            r_byte_idx <= r_byte_idx + 1'b1;
                            r_state    <= S_START;
                            r_tx       <= 1'b0;
                        end else if (w_fifo_nempty) begin
                            // Next frame starts straight out of the stop bit.
                            r_byte_idx   <= '0;
                            r_state      <= S_START;
                            r_tx         <= 1'b0;
                            r_frame_addr <= w_head[ENTRY_W-1 -: 5];
                            r_frame_data <= w_head[BIT_WIDTH-1:0];
                        end else begin
                            r_state <= S_IDLE;
                        end
                    end else begin
                        r_clk_cnt <= r_clk_cnt + 1'b1;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign tx       = r_tx;
    assign overflow = r_overflow;
    assign busy     = (r_state != S_IDLE) || w_fifo_nempty;

endmodule

// File: tb/tb_dft_uart_tx.sv
`timescale 1ns/1ps
module tb_dft_uart_tx;

    localparam int CPB   = 4;
    localparam int BW    = 32;
    localparam int DEPTH = 4;
    localparam int BYTE_CYC = 10 * CPB;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          wr  = 1'b0;
    logic [BW-1:0] addr = '0;
    logic [BW-1:0] data = '0;
    logic          tx;
    logic          busy;
    logic          overflow;

    dft_uart_tx #(
        .BIT_WIDTH    (BW),
        .CLKS_PER_BIT (CPB),
        .FIFO_DEPTH   (DEPTH)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .DFT_RegWrite   (wr),
        .DFT_Address_in (addr),
        .DFT_data       (data),
        .tx             (tx),
        .busy           (busy),
        .overflow       (overflow)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;
    logic [7:0] exp_q[$];
    int starts[$];
    int nbytes = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // UART receiver: samples each bit mid-way, compares against the scoreboard.
    logic       m_active = 1'b0;
    int         m_cnt    = 0;
    logic [7:0] m_byte   = '0;
    always @(negedge clk) begin
        if (rst) begin
            m_active = 1'b0;
        end else if (!m_active) begin
            if (tx === 1'b0) begin
                m_active = 1'b1;
                m_cnt    = 0;
                starts.push_back(cyc);
            end
        end else begin
            m_cnt++;
            if (m_cnt == CPB/2) begin
                check("start_bit", {31'd0, tx}, 32'd0);
            end else if (m_cnt == 9*CPB + CPB/2) begin
                check("stop_bit", {31'd0, tx}, 32'd1);
                nbytes++;
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_byte: got 0x%0h expected none", m_byte);
                end else begin
                    check("rx_byte", {24'd0, m_byte}, {24'd0, exp_q.pop_front()});
                end
                m_active = 1'b0;
            end else if (m_cnt > CPB && (m_cnt % CPB) == CPB/2) begin
                m_byte[m_cnt/CPB - 1] = tx;
            end
        end
    end

    task automatic push_frame(input logic [7:0] abyte, input logic [31:0] d);
        exp_q.push_back(8'hA5);
        exp_q.push_back(abyte);
        exp_q.push_back(d[31:24]);
        exp_q.push_back(d[23:16]);
        exp_q.push_back(d[15:8]);
        exp_q.push_back(d[7:0]);
    endtask

    // Returns #1 after the capture edge.
    task automatic write1(input logic [31:0] a, input logic [31:0] d);
        @(posedge clk); #1;
        wr = 1'b1; addr = a; data = d;
        @(posedge clk); #1;
        wr = 1'b0;
    endtask

    task automatic wait_idle(input int limit, output int fall_cyc);
        fall_cyc = -1;
        for (int i = 0; i < limit; i++) begin
            @(negedge clk);
            if (!busy) begin
                fall_cyc = cyc;
                break;
            end
        end
        if (fall_cyc < 0) begin
            checks++;
            errors++;
            $display("FAIL idle_timeout: busy still 1 after %0d cycles", limit);
        end
    endtask

    task automatic check_run(input string name, input int base_b, input int base_s,
                             input int exp_n, input int fall_cyc);
        int first;
        int last;
        check({name, "_bytes"}, nbytes - base_b, exp_n);
        check({name, "_queue_empty"}, exp_q.size(), 0);
        if (starts.size() > base_s) begin
            first = starts[base_s];
            last  = starts[$];
            check({name, "_no_gaps"}, last - first, (exp_n - 1) * BYTE_CYC);
            check({name, "_duration"}, fall_cyc - first, exp_n * BYTE_CYC);
        end else begin
            checks++;
            errors++;
            $display("FAIL %s_no_start: got 0 start bits expected %0d", name, exp_n);
        end
    endtask

    typedef struct {
        logic [31:0] a;
        logic [31:0] d;
        logic        sends;
        logic [7:0]  abyte;
    } vec_t;

    vec_t vecs[5];

    initial begin
        int fall;
        int bb;
        int bs;
        int quiet_bad;
        int target;
        logic hit;

        vecs[0] = '{32'h0000_0002, 32'h1234_5678, 1'b1, 8'h02};
        vecs[1] = '{32'h0000_0000, 32'hFFFF_FFFF, 1'b0, 8'h00};
        vecs[2] = '{32'h0000_0025, 32'h0000_0000, 1'b1, 8'h05};
        vecs[3] = '{32'h0000_001F, 32'hA55A_00FF, 1'b1, 8'h1F};
        vecs[4] = '{32'h0000_0020, 32'h0000_0001, 1'b0, 8'h00};

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("reset_tx", {31'd0, tx}, 32'd1);
        check("reset_busy", {31'd0, busy}, 32'd0);
        check("reset_overflow", {31'd0, overflow}, 32'd0);
        rst = 1'b0;
        repeat (2) @(posedge clk);

        // Single writes from idle
        for (int i = 0; i < 5; i++) begin
            bb = nbytes;
            bs = starts.size();
            if (vecs[i].sends) push_frame(vecs[i].abyte, vecs[i].d);
            write1(vecs[i].a, vecs[i].d);
            check($sformatf("v%0d_busy_after_capture", i), {31'd0, busy}, {31'd0, vecs[i].sends});
            check($sformatf("v%0d_tx_at_capture", i), {31'd0, tx}, 32'd1);
            @(posedge clk); #1;
            check($sformatf("v%0d_tx_latency", i), {31'd0, tx}, {31'd0, !vecs[i].sends});
            if (vecs[i].sends) begin
                wait_idle(400, fall);
                check_run($sformatf("v%0d", i), bb, bs, 6, fall);
            end else begin
                quiet_bad = 0;
                for (int k = 0; k < 60; k++) begin
                    @(negedge clk);
                    if (tx !== 1'b1 || busy !== 1'b0) quiet_bad++;
                end
                check($sformatf("v%0d_ignored_quiet", i), quiet_bad, 0);
                check($sformatf("v%0d_ignored_bytes", i), nbytes - bb, 0);
            end
        end

        // Overflow: six back-to-back writes, the sixth is dropped
        bb = nbytes;
        bs = starts.size();
        for (int k = 0; k < 6; k++) begin
            @(posedge clk); #1;
            wr   = 1'b1;
            addr = 32'(k + 1);
            data = 32'h1111_1111 * (k + 1);
            if (k < 5) push_frame(8'(k + 1), 32'h1111_1111 * (k + 1));
        end
        @(posedge clk); #1;
        wr = 1'b0;
        check("ovf_flag_set", {31'd0, overflow}, 32'd1);
        wait_idle(1400, fall);
        check_run("ovf", bb, bs, 30, fall);
        check("ovf_flag_sticky", {31'd0, overflow}, 32'd1);

        // Reset in the middle of byte 3
        bb = nbytes;
        bs = starts.size();
        exp_q.push_back(8'hA5);
        exp_q.push_back(8'h03);
        exp_q.push_back(8'hDE);
        write1(32'h3, 32'hDEAD_BEEF);
        hit = 1'b0;
        for (int k = 0; k < 300; k++) begin
            @(negedge clk);
            if (nbytes - bb >= 3) begin
                hit = 1'b1;
                break;
            end
        end
        check("rstmid_reached_byte3", {31'd0, hit}, 32'd1);
        repeat (8) @(posedge clk);
        #1;
        rst = 1'b1;
        wr = 1'b1; addr = 32'h4; data = 32'h1;
        @(posedge clk); #1;
        check("rstmid_tx", {31'd0, tx}, 32'd1);
        check("rstmid_busy", {31'd0, busy}, 32'd0);
        check("rstmid_overflow", {31'd0, overflow}, 32'd0);
        rst = 1'b0;
        wr  = 1'b0;
        quiet_bad = 0;
        for (int k = 0; k < 300; k++) begin
            @(negedge clk);
            if (tx !== 1'b1 || busy !== 1'b0) quiet_bad++;
        end
        check("rstmid_quiet_after", quiet_bad, 0);
        check("rstmid_bytes", nbytes - bb, 3);
        check("rstmid_queue_empty", exp_q.size(), 0);

        // Full FIFO: a write on the frame-end pop edge is accepted
        bb = nbytes;
        bs = starts.size();
        for (int k = 0; k < 5; k++) begin
            @(posedge clk); #1;
            wr   = 1'b1;
            addr = 32'(k + 7);
            data = 32'hC0DE_0000 + 32'(k);
            push_frame(8'(k + 7), 32'hC0DE_0000 + 32'(k));
        end
        @(posedge clk); #1;
        wr = 1'b0;
        check("full_no_overflow_yet", {31'd0, overflow}, 32'd0);
        if (starts.size() > bs) begin
            target = starts[bs] + 6 * BYTE_CYC - 1;
            hit = 1'b0;
            for (int k = 0; k < 400; k++) begin
                if (cyc == target) begin
                    hit = 1'b1;
                    break;
                end
                @(posedge clk); #1;
            end
            check("full_reached_pop_edge", {31'd0, hit}, 32'd1);
            wr = 1'b1; addr = 32'hC; data = 32'hFACE_B00C;
            push_frame(8'h0C, 32'hFACE_B00C);
            @(posedge clk); #1;
            wr = 1'b0;
            check("full_pushpop_overflow", {31'd0, overflow}, 32'd0);
            wait_idle(1700, fall);
            check_run("full", bb, bs, 36, fall);
            check("full_overflow_end", {31'd0, overflow}, 32'd0);
        end else begin
            checks++;
            errors++;
            $display("FAIL full_no_start: got 0 start bits expected 1");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
